// File: rtl/niosii_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker and its read engine.
package niosii_system_sysid_pkg;

    typedef enum logic [1:0] {
        StChkIdle,
        StChkRdId,
        StChkRdTs,
        StChkDone
    } chk_state_e;

    typedef enum logic [1:0] {
        StEngIdle,
        StEngReq,
        StEngWait
    } eng_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    function automatic logic [1:0] mismatch_err(input logic addr);
        return addr ? ERR_TS : ERR_ID;
    endfunction

endpackage

// File: rtl/niosii_system_sysid_rd_engine.sv
// Single Avalon-MM read: request until accepted, wait for readdatavalid, or time out.
module niosii_system_sysid_rd_engine
    import niosii_system_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_addr,
    output logic        o_avm_read,
    output logic        o_avm_address,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_readdatavalid,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_timeout
);

    localparam logic [16:0] TimeoutLim = 17'(TIMEOUT_CYCLES);

    eng_state_e  r_state;
    eng_state_e  w_state_d;
    logic        r_addr;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_d;
    logic [16:0] w_cnt_inc;
    logic        w_active;
    logic        w_accept;
    logic        w_data;
    logic        w_timeout;

    always_comb begin
        w_active  = (r_state == StEngReq) || (r_state == StEngWait);
        w_accept  = (r_state == StEngReq) && !i_avm_waitrequest;
        // Data is only taken in WAIT or in the very cycle the request is accepted.
        w_data    = i_avm_readdatavalid && (w_accept || (r_state == StEngWait));
        w_cnt_inc = {1'b0, r_cnt} + 17'd1;
        // Data landing in the limit cycle beats the timeout.
        w_timeout = w_active && !w_data && (w_cnt_inc == TimeoutLim);
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StEngIdle: begin
                w_state_d = StEngIdle;
            end
            StEngReq: begin
                if (w_data || w_timeout) begin
                    w_state_d = StEngIdle;
                end else if (w_accept) begin
                    w_state_d = StEngWait;
                end
            end
            StEngWait: begin
                if (w_data || w_timeout) begin
                    w_state_d = StEngIdle;
                end
            end
            default: w_state_d = StEngIdle;
        endcase
        if (w_active) begin
            w_cnt_d = w_cnt_inc[15:0];
        end
        if (i_start) begin
            w_state_d = StEngReq;
            w_cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StEngIdle;
            r_cnt   <= '0;
            r_addr  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (i_start) begin
                r_addr <= i_addr;
            end
        end
    end

    assign o_avm_read    = (r_state == StEngReq);
    assign o_avm_address = r_addr & o_avm_read;
    assign o_rsp_valid   = w_data;
    assign o_rsp_data    = i_avm_readdata;
    assign o_rsp_timeout = w_timeout;

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads system ID and build timestamp on start and reports pass/fail.
// Optional SYSID_CHK_RETRY_EN: re-issue a timed-out read up to 3 times, adds retry_count.
module niosii_system_sysid_checker
    import niosii_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486089823,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_CHK_RETRY_EN
    ,
    output logic [1:0]  retry_count
`endif
);

    chk_state_e  r_state;
    chk_state_e  w_state_d;
    logic        r_pass;
    logic        w_pass_d;
    logic        r_fail;
    logic        w_fail_d;
    logic [1:0]  r_err;
    logic [1:0]  w_err_d;
    logic [31:0] r_id;
    logic [31:0] w_id_d;
    logic [31:0] r_ts;
    logic [31:0] w_ts_d;
`ifdef SYSID_CHK_RETRY_EN
    logic [1:0]  r_retry;
    logic [1:0]  w_retry_d;
    logic [1:0]  r_tries;
    logic [1:0]  w_tries_d;
`endif

    logic        w_eng_start;
    logic        w_eng_addr;
    logic        w_cur_addr;
    logic [31:0] w_expected;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_rsp_timeout;

    niosii_system_sysid_rd_engine #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_engine (
        .i_clk               (clock),
        .i_rst_n             (reset_n),
        .i_start             (w_eng_start),
        .i_addr              (w_eng_addr),
        .o_avm_read          (avm_read),
        .o_avm_address       (avm_address),
        .i_avm_waitrequest   (avm_waitrequest),
        .i_avm_readdata      (avm_readdata),
        .i_avm_readdatavalid (avm_readdatavalid),
        .o_rsp_valid         (w_rsp_valid),
        .o_rsp_data          (w_rsp_data),
        .o_rsp_timeout       (w_rsp_timeout)
    );

    always_comb begin
        w_state_d   = r_state;
        w_pass_d    = r_pass;
        w_fail_d    = r_fail;
        w_err_d     = r_err;
        w_id_d      = r_id;
        w_ts_d      = r_ts;
        w_eng_start = 1'b0;
        w_eng_addr  = SYSID_ADDR_ID;
`ifdef SYSID_CHK_RETRY_EN
        w_retry_d   = r_retry;
        w_tries_d   = r_tries;
`endif
        w_cur_addr  = (r_state == StChkRdTs) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        w_expected  = (r_state == StChkRdTs) ? EXPECTED_TIMESTAMP : EXPECTED_ID;

        unique case (r_state)
            StChkIdle: begin
                if (start) begin
                    w_state_d   = StChkRdId;
                    w_eng_start = 1'b1;
                    w_eng_addr  = SYSID_ADDR_ID;
                    w_pass_d    = 1'b0;
                    w_fail_d    = 1'b0;
                    w_err_d     = ERR_NONE;
`ifdef SYSID_CHK_RETRY_EN
                    w_retry_d   = 2'd0;
                    w_tries_d   = 2'd0;
`endif
                end
            end
            StChkRdId, StChkRdTs: begin
                if (w_rsp_valid) begin
                    if (r_state == StChkRdId) begin
                        w_id_d = w_rsp_data;
                    end else begin
                        w_ts_d = w_rsp_data;
                    end
                    if (w_rsp_data != w_expected) begin
                        w_state_d = StChkDone;
                        w_fail_d  = 1'b1;
                        w_err_d   = mismatch_err(w_cur_addr);
                    end else if (r_state == StChkRdId) begin
                        // Chain straight into the timestamp read, no idle gap.
                        w_state_d   = StChkRdTs;
                        w_eng_start = 1'b1;
                        w_eng_addr  = SYSID_ADDR_TS;
`ifdef SYSID_CHK_RETRY_EN
                        w_tries_d   = 2'd0;
`endif
                    end else begin
                        w_state_d = StChkDone;
                        w_pass_d  = 1'b1;
                    end
                end else if (w_rsp_timeout) begin
`ifdef SYSID_CHK_RETRY_EN
                    if (r_tries != 2'd3) begin
                        w_tries_d   = r_tries + 2'd1;
                        w_retry_d   = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;
                        w_eng_start = 1'b1;
                        w_eng_addr  = w_cur_addr;
                    end else
`endif
                    begin
                        w_state_d = StChkDone;
                        w_fail_d  = 1'b1;
                        w_err_d   = ERR_TIMEOUT;
                    end
                end
            end
            StChkDone: begin
                w_state_d = StChkIdle;
            end
            default: w_state_d = StChkIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StChkIdle;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_err   <= ERR_NONE;
            r_id    <= '0;
            r_ts    <= '0;
`ifdef SYSID_CHK_RETRY_EN
            r_retry <= 2'd0;
            r_tries <= 2'd0;
`endif
        end else begin
            r_state <= w_state_d;
            r_pass  <= w_pass_d;
            r_fail  <= w_fail_d;
            r_err   <= w_err_d;
            r_id    <= w_id_d;
            r_ts    <= w_ts_d;
`ifdef SYSID_CHK_RETRY_EN
            r_retry <= w_retry_d;
            r_tries <= w_tries_d;
`endif
        end
    end

    assign busy     = (r_state == StChkRdId) || (r_state == StChkRdTs);
    assign done     = (r_state == StChkDone);
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign err_code = r_err;
    assign id_value = r_id;
    assign ts_value = r_ts;
`ifdef SYSID_CHK_RETRY_EN
    assign retry_count = r_retry;
`endif

endmodule

// File: doc/niosii_system_sysid_checker.md
Name: niosII_system_sysid_checker

Overview:
- Avalon-MM read master; the initiator counterpart of the system ID slave (word 0 = system ID, word 1 = build timestamp).
- On a start pulse, it reads both words through the interconnect and compares them against expected values.
- Reports pass/fail and the captured values so boot/health logic can halt on a hardware/software build mismatch.
- Tolerates interconnect waitrequest and variable readdatavalid latency, with a per-read timeout.

Parameters:
- EXPECTED_ID, 32'h0, expected word-0 value.
- EXPECTED_TIMESTAMP, 32'd1486089823, expected word-1 value.
- TIMEOUT_CYCLES, 255, maximum cycles allowed from read assertion to readdatavalid; range 1..65535.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a check when idle
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  interconnect stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at check completion
- pass  out  1  sticky result: both words matched
- fail  out  1  sticky result: mismatch or timeout
- err_code  out  2  0 = none, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- FSM states:
  - IDLE: `start` -> RD_ID_REQ. Clear pass, fail, err_code. Set busy.
  - RD_ID_REQ: avm_read=1, avm_address=0, held until avm_waitrequest=0 is sampled -> RD_ID_WAIT.
  - RD_ID_WAIT: avm_read=0. On readdatavalid, capture id_value, then:
    - mismatch -> DONE with err 1 (the timestamp read is skipped);
    - match -> RD_TS_REQ.
  - RD_TS_REQ / RD_TS_WAIT: same as the ID read, with address 1. Capture ts_value; mismatch gives err 2.
  - DONE: one cycle. done=1, busy=0, pass/fail set -> IDLE.
- Same-cycle valid: readdatavalid in the same cycle the read is accepted (waitrequest=0) is legal. Data is captured, and the FSM skips the WAIT state.
- Readdatavalid outside a WAIT state or the accepting REQ cycle is ignored.
- Timeout:
  - The counter clears on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES without data captured -> DONE with err 3 and fail. avm_read drops immediately.
  - Data arriving in the same cycle the count reaches the limit wins: no timeout.
- `start` while busy is ignored. `start` in the DONE cycle is ignored.
- Avalon rules:
  - address is stable while avm_read=1.
  - At most one outstanding read; no bursts, no writes.
- pass and fail are mutually exclusive and hold until the next accepted start.
- Reset asserted mid-operation: immediate return to IDLE, avm_read=0, results cleared. A late readdatavalid after reset release is ignored.

Optional Feature:
- Macro: SYSID_CHK_RETRY_EN.
- When defined:
  - A timeout (and only a timeout) re-issues the failing read, up to 3 retries. A 2-bit retry counter resets per check.
  - err 3 is reported only after the 4th consecutive timeout on the same word.
  - Mismatches are never retried.
  - The retry_count output (2 bits) reports retries used in the last check.
- When undefined: the first timeout is final, and the retry_count port is absent.

Decomposition:
- Package niosII_system_sysid_pkg holds:
  - the FSM state encoding;
  - the err_code constants (ERR_NONE, ERR_ID, ERR_TS, ERR_TIMEOUT);
  - the word-address constants (SYSID_ADDR_ID=0, SYSID_ADDR_TS=1).
- One sub-module, niosII_system_sysid_rd_engine, owns the single-read handshake: request, waitrequest, readdatavalid and timeout. It returns a data/valid/timeout result to the top FSM, which sequences the two reads and compares.

Test Plan:
- Zero-wait slave returning 0 and 1486089823 with readdatavalid 1 cycle after accept; start -> done 5-7 cycles later, pass=1, err_code=0, id_value=0, ts_value=1486089823.
- waitrequest held 4 cycles on each read -> avm_address and avm_read stable throughout; pass=1.
- Word 0 returns 32'h1 -> fail=1, err_code=1, no read of address 1 issued, id_value=1.
- Word 1 returns 1486089822 -> fail=1, err_code=2.
- readdatavalid never asserted, TIMEOUT_CYCLES=8 -> avm_read drops, done with err_code=3 at cycle 8. With SYSID_CHK_RETRY_EN: four attempts, then err_code=3 and retry_count=3.
- reset_n pulsed low during RD_TS_WAIT, then a stray readdatavalid -> outputs 0, FSM stays IDLE; a subsequent start completes with pass=1.
